// File: rtl/fpnew_iter_div_lane.sv
// Per-lane restoring radix-2 mantissa divider. Produces WIDTH+2 quotient bits
// plus a sticky bit, ITER_PER_CYCLE bits per clock, under start/kill control.
module fpnew_iter_div_lane #(
    parameter int WIDTH          = 24,
    parameter int ITER_PER_CYCLE = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             kill_i,
    input  logic             lane_en_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             ready_o,
    output logic [WIDTH+1:0] quotient_o,
    output logic             sticky_o,
    output logic             div_zero_o,
    output logic             busy_o
);

    localparam int QW         = WIDTH + 2;
    localparam int N          = (QW + ITER_PER_CYCLE - 1) / ITER_PER_CYCLE;
    localparam int CW         = $clog2(N + 1);
    localparam int LAST_STEPS = QW - (N - 1) * ITER_PER_CYCLE;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [WIDTH:0]  rem_q;
    logic [WIDTH:0]  rem_n;
    logic [WIDTH-1:0] div_q;
    logic [QW-1:0]   work_q;
    logic [QW-1:0]   work_n;
    logic [CW-1:0]   cnt_q;
    logic [QW-1:0]   quot_q;
    logic            sticky_q;
    logic            dz_q;

    // Chained bit steps for one cycle; the last cycle skips steps beyond QW
    // so exactly WIDTH+2 quotient bits are ever shifted in.
    always_comb begin
        rem_n  = rem_q;
        work_n = work_q;
        for (int j = 0; j < ITER_PER_CYCLE; j++) begin
            if (cnt_q != LAST_CNT || j < LAST_STEPS) begin
                if (rem_n >= {1'b0, div_q}) begin
                    rem_n  = rem_n - {1'b0, div_q};
                    work_n = {work_n[QW-2:0], 1'b1};
                end else begin
                    work_n = {work_n[QW-2:0], 1'b0};
                end
                rem_n = {rem_n[WIDTH-1:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            div_q    <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            quot_q   <= '0;
            sticky_q <= 1'b0;
            dz_q     <= 1'b0;
        end else if (kill_i) begin
            state_q  <= IDLE;
            quot_q   <= '0;
            sticky_q <= 1'b0;
            dz_q     <= 1'b0;
        end else if (start_i) begin
            rem_q    <= {1'b0, dividend_i};
            div_q    <= divisor_i;
            work_q   <= '0;
            cnt_q    <= '0;
            quot_q   <= '0;
            sticky_q <= 1'b0;
            dz_q     <= 1'b0;
            if (!lane_en_i) begin
                state_q <= DONE;
            end else if (divisor_i == '0) begin
                state_q <= DONE;
                quot_q  <= '1;
                dz_q    <= 1'b1;
            end else begin
                state_q <= RUN;
            end
        end else if (state_q == RUN) begin
            rem_q  <= rem_n;
            work_q <= work_n;
            cnt_q  <= cnt_q + CW'(1);
            // Result becomes visible only once complete.
            if (cnt_q == LAST_CNT) begin
                state_q  <= DONE;
                quot_q   <= work_n;
                sticky_q <= |rem_n;
            end
        end
    end

    assign ready_o    = (state_q != RUN);
    assign busy_o     = (state_q == RUN);
    assign quotient_o = quot_q;
    assign sticky_o   = sticky_q;
    assign div_zero_o = dz_q;

endmodule
